fetch_queue: RTL and testbench

- Decoupling instruction queue between the fetch stage and decode; replaces the plain IF/ID latch.
- Captures fetch output (instruction, PC+2, imem error) under a valid/ready handshake.
- Absorbs decode stalls without re-fetching, drops wrong-path instructions on a flush, and stops accepting after a HALT.
- Decode sees NOP_INSTR whenever no valid entry is presented.

---
 rtl/fetch_queue_pkg.sv | 32 +++
 rtl/fetch_queue_storage.sv | 38 +++
 rtl/fetch_queue.sv | 126 ++++++++++++
 tb/tb_fetch_queue.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// fetch_queue_pkg
// Constants and types shared by the fetch queue, fetch and decode.
//   INSTR_W   : instruction / PC width
//   NOP_INSTR : encoding decode sees when nothing valid is presented
//   HALT_OPC  : opcode value (bits [15:11]) marking a HALT instruction
//   fq_entry_t: one queue entry {instr, pcinc, err}
// -----------------------------------------------------------------------------
package fetch_queue_pkg;

  localparam int INSTR_W = 16;
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 11;
  localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0800;
  localparam logic [OPC_W-1:0]   HALT_OPC  = 5'b00000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [INSTR_W-1:0] pcinc;
    logic               err;
  } fq_entry_t;

  localparam int ENTRY_W = $bits(fq_entry_t);

  // Extract the opcode field of an instruction.
  function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/fetch_queue_storage.sv
// -----------------------------------------------------------------------------
// fq_storage
// DEPTH x W register array: one synchronous write port, one asynchronous read
// port. Data is not reset; validity is tracked by the owner's count.
//   clk   in  : clock
//   we    in  : write enable
//   waddr in  : write address
//   wdata in  : write data
//   raddr in  : read address
//   rdata out : read data (combinational from the array)
// -----------------------------------------------------------------------------
module fq_storage
#(
  parameter int DEPTH = 2,
  parameter int W     = fetch_queue_pkg::ENTRY_W,
  parameter int AW    = $clog2(DEPTH)
)
(
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_r [DEPTH];

  // Entry write; contents are meaningless until counted valid, so no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Instruction queue between fetch and decode. Captures {instr, PC+2, err}
// under a valid/ready handshake, absorbs decode stalls, drops everything on a
// flush and stops accepting after a HALT has been pushed.
//   clk, rst_n                : clock, async active-low reset
//   f_valid/f_instr/f_pcinc/f_err : fetch side push data
//   f_ready   out : push accepted this cycle (fetch enable)
//   flush     in  : discard all queued and in-flight instructions
//   d_ready   in  : decode consumes the head this cycle
//   d_valid   out : head entry valid
//   d_instr/d_pcinc/d_err out : head entry, or NOP/0/0 when not valid
//   occupancy out : current entry count
// -----------------------------------------------------------------------------
module fetch_queue
#(
  parameter int                                    DEPTH     = 2,
  parameter logic [fetch_queue_pkg::INSTR_W-1:0]   NOP_INSTR = fetch_queue_pkg::NOP_INSTR,
  parameter logic [fetch_queue_pkg::OPC_W-1:0]     HALT_OPC  = fetch_queue_pkg::HALT_OPC
)
(
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  f_valid,
  input  logic [fetch_queue_pkg::INSTR_W-1:0]   f_instr,
  input  logic [fetch_queue_pkg::INSTR_W-1:0]   f_pcinc,
  input  logic                                  f_err,
  output logic                                  f_ready,
  input  logic                                  flush,
  input  logic                                  d_ready,
  output logic                                  d_valid,
  output logic [fetch_queue_pkg::INSTR_W-1:0]   d_instr,
  output logic [fetch_queue_pkg::INSTR_W-1:0]   d_pcinc,
  output logic                                  d_err,
  output logic [$clog2(DEPTH):0]                occupancy
);

  import fetch_queue_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          halt_seen_r;

  logic          push_s;
  logic          pop_s;
  logic          we_s;
  fq_entry_t     wentry_s;
  fq_entry_t     head_s;

  // Both handshake sides depend only on registered state, so there is no
  // combinational path from d_ready to f_ready.
  assign f_ready = (count_r != CW'(DEPTH)) & ~halt_seen_r;
  assign d_valid = (count_r != {CW{1'b0}});
  assign push_s  = f_valid & f_ready;
  assign pop_s   = d_valid & d_ready;
  assign we_s    = push_s & ~flush;

  assign wentry_s = '{instr: f_instr, pcinc: f_pcinc, err: f_err};

  fq_storage #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W),
    .AW    (AW)
  ) u_storage (
    .clk   (clk),
    .we    (we_s),
    .waddr (wr_ptr_r),
    .wdata (wentry_s),
    .raddr (rd_ptr_r),
    .rdata (head_s)
  );

  // Pointer, count and halt bookkeeping; flush overrides any push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      count_r     <= {CW{1'b0}};
      halt_seen_r <= 1'b0;
    end else if (flush) begin
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      count_r     <= {CW{1'b0}};
      halt_seen_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      // The HALT itself is queued; only later pushes are refused.
      if (push_s && (opcode_of(f_instr) == HALT_OPC)) begin
        halt_seen_r <= 1'b1;
      end
    end
  end

  // Head presentation: NOP bubble whenever nothing valid is queued.
  always_comb begin
    d_instr = NOP_INSTR;
    d_pcinc = 16'h0000;
    d_err   = 1'b0;
    if (d_valid) begin
      d_instr = head_s.instr;
      d_pcinc = head_s.pcinc;
      d_err   = head_s.err;
    end else begin
      d_instr = NOP_INSTR;
      d_pcinc = 16'h0000;
      d_err   = 1'b0;
    end
  end

  assign occupancy = count_r;

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
// Directed stimulus for fetch_queue (DEPTH = 2). Accepted pushes enqueue the
// expected {instr, pcinc, err} into a scoreboard queue; a monitor thread pops
// and compares whenever the DUT presents a valid head that decode consumes.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

  logic        clk;
  logic        rst_n;
  logic        f_valid;
  logic [15:0] f_instr;
  logic [15:0] f_pcinc;
  logic        f_err;
  logic        f_ready;
  logic        flush;
  logic        d_ready;
  logic        d_valid;
  logic [15:0] d_instr;
  logic [15:0] d_pcinc;
  logic        d_err;
  logic [1:0]  occupancy;

  int total = 0;
  int bad   = 0;
  logic [32:0] exp_q [$];

  fetch_queue #(.DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .f_valid   (f_valid),
    .f_instr   (f_instr),
    .f_pcinc   (f_pcinc),
    .f_err     (f_err),
    .f_ready   (f_ready),
    .flush     (flush),
    .d_ready   (d_ready),
    .d_valid   (d_valid),
    .d_instr   (d_instr),
    .d_pcinc   (d_pcinc),
    .d_err     (d_err),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction for one cycle; acc is the hand-computed f_ready.
  task automatic issue(input logic [15:0] i, input logic [15:0] p, input logic e,
                       input logic acc, input int occ_max);
    f_valid = 1'b1;
    f_instr = i;
    f_pcinc = p;
    f_err   = e;
    @(negedge clk);
    check("f_ready", f_ready, acc);
    check("occ_bound", (int'(occupancy) <= occ_max), 1'b1);
    if (acc) exp_q.push_back({i, p, e});
    step();
  endtask

  initial begin
    rst_n   = 1'b0;
    f_valid = 1'b0;
    f_instr = 16'h0000;
    f_pcinc = 16'h0000;
    f_err   = 1'b0;
    flush   = 1'b0;
    d_ready = 1'b0;

    // Monitor: compare every consumed head against the scoreboard.
    fork
      forever begin
        @(negedge clk);
        if (rst_n && d_valid && d_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_head: got %h/%h/%b expected none", d_instr, d_pcinc, d_err);
          end else begin
            check("head", {d_instr, d_pcinc, d_err}, exp_q.pop_front());
          end
        end
      end
    join_none

    // Reset then idle
    @(negedge clk);
    check("rst_d_valid", d_valid, 1'b0);
    check("rst_d_instr", d_instr, 16'h0800);
    check("rst_d_pcinc", d_pcinc, 16'h0000);
    check("rst_d_err", d_err, 1'b0);
    check("rst_occ", occupancy, 2'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_f_ready", f_ready, 1'b1);
    check("idle_d_valid", d_valid, 1'b0);
    check("idle_d_instr", d_instr, 16'h0800);
    check("idle_occ", occupancy, 2'd0);
    step();

    // Streaming at one per cycle
    d_ready = 1'b1;
    issue(16'h4001, 16'h0002, 1'b0, 1'b1, 0);
    issue(16'h4002, 16'h0004, 1'b1, 1'b1, 1);
    issue(16'h4003, 16'h0006, 1'b0, 1'b1, 1);
    f_valid = 1'b0;
    @(negedge clk);
    check("stream_occ", occupancy, 2'd1);
    step();
    @(negedge clk);
    check("stream_empty_valid", d_valid, 1'b0);
    check("stream_empty_occ", occupancy, 2'd0);
    step();

    // Backpressure
    d_ready = 1'b0;
    issue(16'hA111, 16'h0010, 1'b0, 1'b1, 0);
    issue(16'hA222, 16'h0012, 1'b0, 1'b1, 1);
    issue(16'hA333, 16'h0014, 1'b0, 1'b0, 2);
    f_valid = 1'b0;
    @(negedge clk);
    check("bp_occ_full", occupancy, 2'd2);
    check("bp_f_ready_full", f_ready, 1'b0);
    step();
    d_ready = 1'b1;
    @(negedge clk);
    check("bp_f_ready_before_pop", f_ready, 1'b0);
    step();
    @(negedge clk);
    check("bp_f_ready_after_pop", f_ready, 1'b1);
    step();
    @(negedge clk);
    check("bp_drained_occ", occupancy, 2'd0);
    step();

    // Flush while full, with a pop and a blocked push in the flush cycle
    d_ready = 1'b0;
    issue(16'hB001, 16'h0020, 1'b0, 1'b1, 0);
    issue(16'hB002, 16'h0022, 1'b0, 1'b1, 1);
    f_valid = 1'b1;
    f_instr = 16'hB003;
    f_pcinc = 16'h0024;
    flush   = 1'b1;
    d_ready = 1'b1;
    @(negedge clk);
    check("fl1_f_ready_full", f_ready, 1'b0);
    step();
    exp_q.delete();
    flush   = 1'b0;
    f_valid = 1'b0;
    d_ready = 1'b0;
    @(negedge clk);
    check("fl1_occ", occupancy, 2'd0);
    check("fl1_d_valid", d_valid, 1'b0);
    check("fl1_d_instr", d_instr, 16'h0800);
    check("fl1_f_ready", f_ready, 1'b1);
    step();

    // Flush with push and pop in the same cycle, held for two cycles
    issue(16'hB011, 16'h0030, 1'b0, 1'b1, 0);
    f_valid = 1'b1;
    f_instr = 16'hB012;
    f_pcinc = 16'h0032;
    flush   = 1'b1;
    d_ready = 1'b1;
    @(negedge clk);
    check("fl2_f_ready", f_ready, 1'b1);
    step();
    exp_q.delete();
    @(negedge clk);
    check("fl2_hold_occ", occupancy, 2'd0);
    check("fl2_hold_valid", d_valid, 1'b0);
    step();
    flush   = 1'b0;
    f_valid = 1'b0;
    @(negedge clk);
    check("fl2_occ", occupancy, 2'd0);
    check("fl2_d_valid", d_valid, 1'b0);
    check("fl2_d_instr", d_instr, 16'h0800);
    check("fl2_d_pcinc", d_pcinc, 16'h0000);
    check("fl2_f_ready", f_ready, 1'b1);
    step();

    // HALT: queued and delivered, later fetches refused until flush
    d_ready = 1'b1;
    issue(16'h0000, 16'h0040, 1'b0, 1'b1, 0);
    issue(16'h4004, 16'h0042, 1'b0, 1'b0, 1);
    issue(16'h4004, 16'h0042, 1'b0, 1'b0, 1);
    f_valid = 1'b0;
    @(negedge clk);
    check("halt_f_ready", f_ready, 1'b0);
    check("halt_d_valid", d_valid, 1'b0);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    check("halt_flush_f_ready", f_ready, 1'b1);
    step();

    // Asynchronous reset between clock edges
    d_ready = 1'b0;
    issue(16'hC001, 16'h0050, 1'b0, 1'b1, 0);
    issue(16'hC002, 16'h0052, 1'b1, 1'b1, 1);
    f_valid = 1'b0;
    @(negedge clk);
    check("ar_occ_before", occupancy, 2'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_d_valid", d_valid, 1'b0);
    check("ar_d_instr", d_instr, 16'h0800);
    check("ar_d_pcinc", d_pcinc, 16'h0000);
    check("ar_d_err", d_err, 1'b0);
    check("ar_occ", occupancy, 2'd0);
    exp_q.delete();
    step();
    rst_n = 1'b1;

    // Error-flagged entry after reset is delivered unchanged
    d_ready = 1'b1;
    issue(16'hD001, 16'h0060, 1'b1, 1'b1, 0);
    f_valid = 1'b0;
    @(negedge clk);
    check("err_occ", occupancy, 2'd1);
    step();
    @(negedge clk);
    check("err_drained_valid", d_valid, 1'b0);
    step();

    check("scoreboard_drained", exp_q.size(), 33'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
